lsu_unit: RTL and testbench

LSU_UNIT -- requirements
Module: lsu_unit

---
 rtl/lsu_unit_if.sv | 20 ++
 rtl/lsu_unit.sv | 122 ++++++++++++
 tb/tb_lsu_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_unit_if.sv
// Byte-wide memory bus with a valid/ready handshake between the load/store unit
// (master) and the memory (slave).
interface lsu_unit_if;
   logic        mem_valid;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ready;
   logic [7:0]  mem_rdata;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/lsu_unit.sv
// Single-outstanding load/store unit: latches a request, runs one memory handshake
// with a bounded wait, then pulses a one-cycle response with register/pointer write-back.
module lsu_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        op_store,
   input  logic [15:0] ptr,
   input  logic [7:0]  st_data,
   input  logic [3:0]  dst_sel,
   input  logic        inc,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        rf_we,
   output logic [3:0]  rf_sel,
   output logic [7:0]  rf_din,
   output logic        ptr_we,
   output logic [15:0] ptr_out,
   lsu_unit_if.master  mem
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt;
   logic [15:0] ptr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;
   logic [3:0]  dst_q;
   logic        store_q;
   logic        inc_q;
   logic        err_q;
   logic        accept;
   logic        handshake;
   logic        timeout;
   logic        in_access;
   logic        in_resp;

   // NOTE: reset is asynchronous so the bus drops the moment reset asserts;
   // state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      handshake = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               accept  = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (mem.mem_ready) begin
               handshake = 1'b1;
               state_d   = RESP;
            end else if (wait_cnt == LAST_WAIT) begin
               timeout = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
         ptr_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         dst_q    <= '0;
         store_q  <= 1'b0;
         inc_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            wait_cnt <= '0;
            ptr_q    <= ptr;
            wdata_q  <= st_data;
            dst_q    <= dst_sel;
            store_q  <= op_store;
            inc_q    <= inc;
            err_q    <= 1'b0;
         end
         if (state_q == ACCESS && !mem.mem_ready) wait_cnt <= wait_cnt + 8'd1;
         if (handshake && !store_q) rdata_q <= mem.mem_rdata;
         if (timeout) err_q <= 1'b1;
      end
   end

   assign in_access = (state_q == ACCESS);
   assign in_resp   = (state_q == RESP);

   assign mem.mem_valid = in_access;
   assign mem.mem_we    = in_access & store_q;
   assign mem.mem_addr  = in_access ? ptr_q : 16'h0000;
   assign mem.mem_wdata = in_access ? wdata_q : 8'h00;

   // Write-back strobes are qualified by the error flag; data buses stay zero unless strobed.
   assign busy    = in_access | in_resp;
   assign done    = in_resp;
   assign err     = in_resp & err_q;
   assign rf_we   = in_resp & ~store_q & ~err_q;
   assign rf_sel  = rf_we ? dst_q : 4'h0;
   assign rf_din  = rf_we ? rdata_q : 8'h00;
   assign ptr_we  = in_resp & inc_q & ~err_q;
   assign ptr_out = ptr_we ? (ptr_q + 16'd1) : 16'h0000;

endmodule

// File: tb/tb_lsu_unit.sv
// Randomized scoreboard bench for lsu_unit: stimulus pushes expected responses,
// an independent monitor compares bus activity and response pulses as they appear.
module tb_lsu_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic        op_store = 1'b0;
   logic [15:0] ptr = '0;
   logic [7:0]  st_data = '0;
   logic [3:0]  dst_sel = '0;
   logic        inc = 1'b0;
   logic        busy, done, err, rf_we, ptr_we;
   logic [3:0]  rf_sel;
   logic [7:0]  rf_din;
   logic [15:0] ptr_out;

   lsu_unit_if mem_bus();

   lsu_unit #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .op_store (op_store),
      .ptr      (ptr),
      .st_data  (st_data),
      .dst_sel  (dst_sel),
      .inc      (inc),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .rf_we    (rf_we),
      .rf_sel   (rf_sel),
      .rf_din   (rf_din),
      .ptr_we   (ptr_we),
      .ptr_out  (ptr_out),
      .mem      (mem_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        store;
      bit [15:0] addr;
      bit [7:0]  wdata;
      int        cycles;
      bit        err;
      bit        rf_we;
      bit [3:0]  rf_sel;
      bit [7:0]  rf_din;
      bit        ptr_we;
      bit [15:0] ptr_out;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the transaction outcome follows directly from the ready delay.
   task automatic run_txn(input bit store, input logic [15:0] p, input logic [7:0] d,
                          input logic [3:0] dst, input bit do_inc, input int delay,
                          input logic [7:0] rdata, input bit hold_req);
      exp_t e;
      bit   timed_out;
      int   n;
      timed_out = (delay >= TO);
      n         = timed_out ? TO : delay + 1;
      e.store   = store;
      e.addr    = p;
      e.wdata   = d;
      e.cycles  = n;
      e.err     = timed_out;
      e.rf_we   = !store && !timed_out;
      e.rf_sel  = dst;
      e.rf_din  = rdata;
      e.ptr_we  = do_inc && !timed_out;
      e.ptr_out = 16'((int'(p) + 1) % 65536);
      @(negedge clk);
      exp_q.push_back(e);
      req = 1'b1; op_store = store; ptr = p; st_data = d; dst_sel = dst; inc = do_inc;
      mem_bus.mem_ready = 1'b0;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req      = hold_req;
         op_store = 1'($urandom);
         ptr      = 16'($urandom);
         st_data  = 8'($urandom);
         dst_sel  = 4'($urandom);
         inc      = 1'($urandom);
         mem_bus.mem_ready = (i == delay);
         mem_bus.mem_rdata = (i == delay) ? rdata : 8'($urandom);
         @(posedge clk);
      end
      @(negedge clk);
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 8'($urandom);
      @(posedge clk);
      #1 req = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      int   acc = 0;
      forever begin
         @(negedge clk);
         #1;
         if (!reset) begin
            check("reset_ctrl_zero", {busy, done, err, rf_we, ptr_we, mem_bus.mem_valid, mem_bus.mem_we}, 0);
            check("reset_data_zero", {rf_sel, rf_din, ptr_out, mem_bus.mem_addr, mem_bus.mem_wdata}, 0);
            acc = 0;
         end else begin
            check("busy_vs_phase", busy, mem_bus.mem_valid | done);
            check("valid_done_exclusive", mem_bus.mem_valid & done, 0);
            if (mem_bus.mem_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_access", mem_bus.mem_valid, 0);
               end else begin
                  e = exp_q[0];
                  acc++;
                  check("mem_addr", mem_bus.mem_addr, e.addr);
                  check("mem_we", mem_bus.mem_we, e.store);
                  if (e.store) check("mem_wdata", mem_bus.mem_wdata, e.wdata);
               end
            end else begin
               check("mem_idle_zero", {mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}, 0);
            end
            if (done) begin
               if (exp_q.size() == 0) begin
                  check("spurious_done", done, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("access_cycles", acc, e.cycles);
                  check("err", err, e.err);
                  check("rf_we", rf_we, e.rf_we);
                  check("ptr_we", ptr_we, e.ptr_we);
                  if (e.rf_we) begin
                     check("rf_sel", rf_sel, e.rf_sel);
                     check("rf_din", rf_din, e.rf_din);
                  end
                  if (e.ptr_we) check("ptr_out", ptr_out, e.ptr_out);
               end
               acc = 0;
            end else begin
               check("resp_idle_zero", {err, rf_we, rf_sel, rf_din, ptr_we, ptr_out}, 0);
            end
         end
      end
   end

   initial begin : stimulus
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Directed: load, delayed store with wrap of low byte, pointer wrap, timeouts.
      run_txn(1'b0, 16'h1234, 8'h00, 4'd5, 1'b0, 0, 8'hA7, 1'b0);
      run_txn(1'b1, 16'h00FF, 8'h3C, 4'd0, 1'b1, 3, 8'h00, 1'b0);
      run_txn(1'b0, 16'hFFFF, 8'h00, 4'd9, 1'b1, 0, 8'h5A, 1'b0);
      run_txn(1'b1, 16'h2000, 8'h11, 4'd0, 1'b1, 50, 8'h00, 1'b0);
      run_txn(1'b0, 16'h3000, 8'h00, 4'd2, 1'b1, TO, 8'hEE, 1'b0);
      run_txn(1'b0, 16'h4000, 8'h00, 4'd3, 1'b1, TO - 1, 8'h99, 1'b0);
      run_txn(1'b0, 16'h5555, 8'h00, 4'd7, 1'b1, 2, 8'hC3, 1'b1);

      for (int k = 0; k < 40; k++) begin
         run_txn(1'($urandom), 16'($urandom), 8'($urandom), 4'($urandom), 1'($urandom),
                 int'($urandom_range(0, 5)), 8'($urandom), 1'($urandom));
      end

      // Reset in the middle of an access: bus drops at once, no response follows.
      @(negedge clk);
      begin
         exp_t e;
         e = '{store: 1'b0, addr: 16'h4321, wdata: 8'h00, cycles: TO, err: 1'b0, rf_we: 1'b1,
               rf_sel: 4'd1, rf_din: 8'h00, ptr_we: 1'b1, ptr_out: 16'h4322};
         exp_q.push_back(e);
      end
      req = 1'b1; op_store = 1'b0; ptr = 16'h4321; dst_sel = 4'd1; inc = 1'b1;
      mem_bus.mem_ready = 1'b0;
      @(posedge clk);
      #1 req = 1'b0;
      @(posedge clk);
      #2;
      check("pre_reset_valid", mem_bus.mem_valid, 1);
      reset = 1'b0;
      #1;
      check("reset_async_valid", mem_bus.mem_valid, 0);
      check("reset_async_busy", busy, 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(posedge clk);

      run_txn(1'b0, 16'h0BAD, 8'h00, 4'd12, 1'b1, 1, 8'h6E, 1'b0);
      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
